// File: rtl/seg7_scan.sv
// Four-digit multiplexed common-anode seven-segment driver with title/result/guess modes.
// Build option: define SEG7_BLINK_EN to blink marked digits instead of lighting their dp.
module seg7_scan #(
   parameter int SCAN_CYCLES  = 100000,
   parameter int BLINK_CYCLES = 25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] signal,
   input  logic [3:0]  digit_selected,
   input  logic        is_title,
   input  logic        is_result,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int SCAN_W = $clog2(SCAN_CYCLES);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
   localparam logic [15:0] TITLE_TEXT = 16'h1a2b;
   localparam logic [6:0] SEG_BLANK = 7'h7f;

   logic [SCAN_W-1:0] scan_cnt;
   logic [1:0]        idx;
   logic [3:0]        nib;
   logic              marked;
   logic [6:0]        seg_d;
   logic              dp_d;

   function automatic logic [6:0] decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'ha:    s = 7'h08;
         4'hb:    s = 7'h03;
         4'he:    s = 7'h3f;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

`ifdef SEG7_BLINK_EN
   localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_on;
   logic [3:0]         sel_prev;

   // A selection change restarts the on-phase so the new digit lights at once.
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
         sel_prev  <= 4'b0000;
      end else begin
         sel_prev <= digit_selected;
         if (digit_selected != sel_prev) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
         end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end
`endif

   always_comb begin
      nib    = signal[{idx, 2'b00} +: 4];
      marked = 1'b0;
      if (is_title) begin
         nib = TITLE_TEXT[{idx, 2'b00} +: 4];
      end else if (!is_result) begin
         marked = digit_selected[idx];
      end
      seg_d = decode(nib);
      dp_d  = 1'b1;
`ifdef SEG7_BLINK_EN
      if (marked && !blink_on) seg_d = SEG_BLANK;
`else
      if (marked) dp_d = 1'b0;
`endif
   end

   // Last cycle of each slot drives everything dark to avoid ghosting.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         idx      <= 2'd0;
         an       <= 4'b1111;
         seg      <= SEG_BLANK;
         dp       <= 1'b1;
      end else begin
         if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
            an       <= 4'b1111;
            seg      <= SEG_BLANK;
            dp       <= 1'b1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
            an       <= ~(4'b0001 << idx);
            seg      <= seg_d;
            dp       <= dp_d;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with SCAN_CYCLES=4, BLINK_CYCLES=8.
// Blink-specific expectations follow the SEG7_BLINK_EN build option.
module tb_seg7_scan;

   logic        clk;
   logic        rst;
   logic [15:0] signal;
   logic [3:0]  digit_selected;
   logic        is_title;
   logic        is_result;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int passed = 0;
   int total  = 0;
   int k      = 0;

   typedef struct {
      string       name;
      logic [15:0] sig;
      logic [3:0]  sel;
      logic        title;
      logic        result;
      logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
      logic [3:0]  dpm;    // expected dp per digit
   } vec_t;

   vec_t vecs[$];

   seg7_scan #(.SCAN_CYCLES(4), .BLINK_CYCLES(8)) dut (
      .clk(clk),
      .rst(rst),
      .signal(signal),
      .digit_selected(digit_selected),
      .is_title(is_title),
      .is_result(is_result),
      .an(an),
      .seg(seg),
      .dp(dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] ea, input logic [6:0] es, input logic ed);
      total++;
      if (an === ea && seg === es && dp === ed) begin
         passed++;
      end else begin
         $display("FAIL %s (k=%0d): got an=%b seg=%h dp=%b, required an=%b seg=%h dp=%b",
                  name, k, an, seg, dp, ea, es, ed);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected outputs at scan position k given per-digit seg/dp expectations.
   task automatic check_scan(input string name, input logic [27:0] segs, input logic [3:0] dpm);
      int slot;
      int d;
      logic [27:0] s;
      logic [3:0]  m;
      s = segs;
      m = dpm;
      slot = k % 4;
      d = (k / 4) % 4;
      if (slot == 3) check(name, 4'b1111, 7'h7f, 1'b1);
      else check(name, ~(4'b0001 << d), s[d*7 +: 7], m[d]);
   endtask

   initial begin
      vecs.push_back('{"scan_1234",     16'h1234, 4'b0000, 1'b0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111});
      vecs.push_back('{"title_prio",    16'h0000, 4'b0000, 1'b1, 1'b1, {7'h79, 7'h08, 7'h24, 7'h03}, 4'b1111});
      vecs.push_back('{"result",        16'hb2a1, 4'b0000, 1'b0, 1'b1, {7'h03, 7'h24, 7'h08, 7'h79}, 4'b1111});
      vecs.push_back('{"empty_undef",   16'heecf, 4'b0000, 1'b0, 1'b0, {7'h3f, 7'h3f, 7'h7f, 7'h7f}, 4'b1111});
      vecs.push_back('{"title_no_mark", 16'hffff, 4'b1111, 1'b1, 1'b0, {7'h79, 7'h08, 7'h24, 7'h03}, 4'b1111});
      vecs.push_back('{"result_no_mark",16'hb2a1, 4'b0010, 1'b0, 1'b1, {7'h03, 7'h24, 7'h08, 7'h79}, 4'b1111});
`ifndef SEG7_BLINK_EN
      vecs.push_back('{"steady_mark",   16'h0005, 4'b0010, 1'b0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h12}, 4'b1101});
      vecs.push_back('{"multi_mark",    16'h6789, 4'b1001, 1'b0, 1'b0, {7'h02, 7'h78, 7'h00, 7'h10}, 4'b0110});
`endif

      rst = 1'b1;
      signal = 16'h1234;
      digit_selected = 4'b0000;
      is_title = 1'b0;
      is_result = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("reset_hold", 4'b1111, 7'h7f, 1'b1);
      end
      rst = 1'b0;
      k = 0;

`ifdef SEG7_BLINK_EN
      // Blink sequence: restart at k=7, off-phases 16..23 and 32..33, restart again at k=33.
      signal = 16'h0005;
      for (int i = 0; i < 48; i++) begin
         int d;
         logic on;
         logic [6:0] es;
         logic [3:0] sel;
         sel = (k < 7) ? 4'b0000 : (k < 33) ? 4'b1111 : 4'b0100;
         digit_selected = sel;
         step();
         on = (k <= 15) || (k >= 24 && k <= 31) || (k >= 34 && k <= 41);
         d = (k / 4) % 4;
         es = (d == 0) ? 7'h12 : 7'h40;
         if (sel[d] && !on) es = 7'h7f;
         if (k % 4 == 3) check("blink", 4'b1111, 7'h7f, 1'b1);
         else check("blink", ~(4'b0001 << d), es, 1'b1);
         k++;
      end
      digit_selected = 4'b0000;
`endif

      foreach (vecs[v]) begin
         signal = vecs[v].sig;
         digit_selected = vecs[v].sel;
         is_title = vecs[v].title;
         is_result = vecs[v].result;
         for (int i = 0; i < 16; i++) begin
            step();
            check_scan(vecs[v].name, vecs[v].segs, vecs[v].dpm);
            k++;
         end
      end

      // Mid-scan reset, then scanning resumes at digit 0.
      signal = 16'h1234;
      digit_selected = 4'b0000;
      is_title = 1'b0;
      is_result = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         check_scan("pre_rst", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111);
         k++;
      end
      rst = 1'b1;
      step();
      check("rst_mid", 4'b1111, 7'h7f, 1'b1);
      step();
      check("rst_mid_hold", 4'b1111, 7'h7f, 1'b1);
      rst = 1'b0;
      k = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         check_scan("post_rst", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111);
         k++;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Four-digit multiplexed seven-segment driver that consumes the game controller's display outputs (`signal`, `digitSelected`, `istitle`, `isresult`) and drives the board's common-anode display. Nibble i of `signal` appears on digit i, with `an[3]` the leftmost digit. It decodes 0–9 and the letters A/b, shows empty slots (4'he) as a dash, and forces the "1A2b" banner on the title screen. It also marks the selected digit while guessing.

## Interface
- `SCAN_CYCLES`, default 100000: clock cycles each digit stays active, including one guard cycle. Must be ≥ 2.
- `BLINK_CYCLES`, default 25000000: half-period of the selected-digit blink, in cycles. Must be ≥ 1.

- `clk` in 1: system clock; single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `signal` in 16: four display nibbles; [3:0] maps to digit 0.
- `digit_selected` in 4: selected-digit mask from the controller (normally one-hot or zero).
- `is_title` in 1: title screen active.
- `is_result` in 1: result screen active.
- `an` out 4: digit enables, active-low.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp` out 1: decimal point, active-low.

## Operation
- Nibble decode (seg value) is fixed:
  - 0–9: 40 79 24 30 19 12 02 78 00 10
  - 4'ha ('A'): 08
  - 4'hb ('b'): 03
  - 4'he (dash): 3F
  - 4'hc, 4'hd, 4'hf: blank, 7F
- Mode priority: `is_title` > `is_result` > guess mode.
- Title mode: `signal` and `digit_selected` are ignored. Digits 3..0 show 1, A, 2, b; `dp` is off.
- Result mode: nibbles are decoded verbatim; no marking; `dp` is off.
- Guess mode: digit i is marked when `digit_selected[i]` = 1. Multiple set bits mark multiple digits; zero marks none.
- Scan counter `scan_cnt` counts 0..SCAN_CYCLES-1 and wraps. On the wrap edge the digit index `idx` (2 bits) increments mod 4: order 0, 1, 2, 3, 0.
- Blink counter `blink_cnt` counts 0..BLINK_CYCLES-1. On wrap it toggles `blink_on`.
- Blink restart: any cycle where `digit_selected` differs from its registered previous value forces `blink_cnt` = 0 and `blink_on` = 1 at the next edge. A newly selected digit is therefore lit immediately.

## Timing
- `an`, `seg` and `dp` are registered outputs with one cycle of latency from `scan_cnt`, `idx` and the inputs at the edge.
- Guard cycle: when `scan_cnt` = SCAN_CYCLES-1, the next outputs are `an` = 4'b1111, `seg` = 7F, `dp` = 1 (anti-ghosting).
- Otherwise `an` = ~(4'b0001 << idx), and `seg`/`dp` carry the content of digit `idx`.
- A change on `signal` appears on the active digit at the first edge after the change, except in a guard cycle.
- Reset values, held while `rst` = 1:
  - `an` = 4'b1111, `seg` = 7F, `dp` = 1
  - `scan_cnt` = 0, `idx` = 0
  - `blink_cnt` = 0, `blink_on` = 1
  - previous-`digit_selected` register = 0
- Reset mid-scan or mid-blink: all state returns to the reset values at that edge. Scanning resumes at digit 0 the first edge after `rst` falls.
- A mode change takes effect on the next non-guard output cycle; no counter restarts.

## Configuration
- `SEG7_BLINK_EN` defined: a marked digit shows its decoded value while `blink_on` = 1 and is blanked (7F) while `blink_on` = 0. `dp` stays off.
- `SEG7_BLINK_EN` undefined: the blink counter and the previous-`digit_selected` register are omitted. A marked digit shows its decoded value steadily with `dp` = 0.

## Test plan
Benches use SCAN_CYCLES = 4 and BLINK_CYCLES = 8.
- Reset then scan: `rst` high for 3 cycles, then released, `signal` = 16'h1234, guess mode, no selection.
  - `an` sequence: 1110 ×3, 1111, 1101 ×3, 1111, 1011 ×3, 1111, 0111 ×3, 1111, repeating.
  - `seg`: 19 on digit 0, 30 on digit 1, 24 on digit 2, 79 on digit 3.
- Title priority: `is_title` = 1, `is_result` = 1, `signal` = 16'h0000.
  - Digit 3 = 79, digit 2 = 08, digit 1 = 24, digit 0 = 03; `dp` = 1 throughout.
- Result screen: `is_result` = 1, `signal` = 16'hb2a1.
  - Digit 0 = 79, digit 1 = 08, digit 2 = 24, digit 3 = 03.
- Empty and undefined nibbles: guess mode, `signal` = 16'heecf.
  - Digit 0 = 7F, digit 1 = 7F, digits 2 and 3 = 3F.
- Blink, with `SEG7_BLINK_EN` defined: `digit_selected` = 0010, `signal` = 16'h0005.
  - Digit 1 shows 40 for 8 cycles, then 7F for 8 cycles, alternating.
  - Changing `digit_selected` to 0100 mid-off-phase makes digit 2 visible on its next active slot and restarts the 8-cycle on-phase.
- No-blink build, `SEG7_BLINK_EN` undefined, same stimulus:
  - Digit 1 is steady 40 with `dp` = 0; all other digits have `dp` = 1.
  - Asserting `rst` mid-scan gives `an` = 1111 and `seg` = 7F at the next edge.
